// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard controller.
// Register index and hazard FSM state encoding.
package cpu_types_pkg;

   typedef logic [4:0] regbits_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DWAIT = 2'd1,
      HALT  = 2'd2
   } hazstate_t;

   // Load in EX feeds a register decode reads; $zero never hazards.
   function automatic logic load_use(
      input logic     mem_read,
      input regbits_t wr,
      input logic     use_rs,
      input regbits_t rs,
      input logic     use_rt,
      input regbits_t rt
   );
      return mem_read && (wr != '0) &&
             ((use_rs && (rs == wr)) ||
              (use_rt && (rt == wr)));
   endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline control bundle between hazard unit and datapath.
// Counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_if #(
   parameter int CNT_W = 32
);
   import cpu_types_pkg::*;

   typedef logic [CNT_W-1:0] cnt_t;

   regbits_t rsel1;
   regbits_t rsel2;
   logic     use_rs;
   logic     use_rt;
   logic     ex_memRead;
   regbits_t ex_writeReg;
   logic     mem_dREN;
   logic     mem_dWEN;
   logic     dhit;
   logic     ihit;
   logic     mem_pcsrc;
   logic     wb_halt;
   logic     pc_en;
   logic     ifid_en;
   logic     idex_en;
   logic     exmem_en;
   logic     memwb_en;
   logic     ifid_flush;
   logic     idex_flush;
   logic     exmem_flush;
   logic     memwb_flush;
   logic     halted;
`ifdef HAZARD_PERF_EN
   cnt_t     stall_cnt;
   cnt_t     flush_cnt;
`endif

   modport hazard (
      input  rsel1, rsel2, use_rs, use_rt,
      input  ex_memRead, ex_writeReg,
      input  mem_dREN, mem_dWEN, dhit, ihit,
      input  mem_pcsrc, wb_halt,
`ifdef HAZARD_PERF_EN
      output stall_cnt, flush_cnt,
`endif
      output pc_en, ifid_en, idex_en,
      output exmem_en, memwb_en,
      output ifid_flush, idex_flush,
      output exmem_flush, memwb_flush,
      output halted
   );

   modport pipeline (
      output rsel1, rsel2, use_rs, use_rt,
      output ex_memRead, ex_writeReg,
      output mem_dREN, mem_dWEN, dhit, ihit,
      output mem_pcsrc, wb_halt,
`ifdef HAZARD_PERF_EN
      input  stall_cnt, flush_cnt,
`endif
      input  pc_en, ifid_en, idex_en,
      input  exmem_en, memwb_en,
      input  ifid_flush, idex_flush,
      input  exmem_flush, memwb_flush,
      input  halted
   );

endinterface

// File: rtl/hazard_perf_ctr.sv
// Enable-gated free-running counter, wraps modulo 2^W.
// Used for stall/flush statistics under HAZARD_PERF_EN.
module hazard_perf_ctr #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: bump when enabled, natural wrap
   always_comb begin
      cnt_d = cnt_q;
      if (en) cnt_d = cnt_q + 1'b1;
   end

   // count register, synchronous clear
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/halt control for the five-stage pipeline.
// Optional perf counters: define HAZARD_PERF_EN.
module hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic      CLK,
   input logic      RST,
   hazard_if.hazard hz
);

   typedef logic [CNT_W-1:0] cnt_t;

   hazstate_t state_q;
   hazstate_t state_d;

   logic dwait;
   logic lu;
   logic br_apply;
   logic pc_en;
   logic ifid_en;
   logic idex_en;
   logic exmem_en;
   logic memwb_en;
   logic ifid_fl;
   logic idex_fl;
   logic exmem_fl;
   logic memwb_fl;
   logic halted;

   // next state plus prioritised Mealy control outputs
   always_comb begin
      state_d  = state_q;
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      ifid_fl  = 1'b0;
      idex_fl  = 1'b0;
      exmem_fl = 1'b0;
      memwb_fl = 1'b0;
      halted   = 1'b0;
      br_apply = 1'b0;
      dwait = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;
      lu = load_use(hz.ex_memRead, hz.ex_writeReg,
                    hz.use_rs, hz.rsel1,
                    hz.use_rt, hz.rsel2);

      case (state_q)
         RUN:     if (dwait) state_d = DWAIT;
         DWAIT:   if (hz.dhit) state_d = RUN;
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
      if (hz.wb_halt) state_d = HALT;

      if (state_q == HALT) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
         halted   = 1'b1;
      end else if (dwait) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else if (hz.mem_pcsrc) begin
         ifid_fl  = 1'b1;
         idex_fl  = 1'b1;
         exmem_fl = 1'b1;
         br_apply = 1'b1;
      end else if (lu) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_fl  = 1'b1;
      end else if (!hz.ihit) begin
         pc_en    = 1'b0;
         ifid_fl  = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RST) state_q <= RUN;
      else     state_q <= state_d;
   end

   assign hz.pc_en       = pc_en;
   assign hz.ifid_en     = ifid_en;
   assign hz.idex_en     = idex_en;
   assign hz.exmem_en    = exmem_en;
   assign hz.memwb_en    = memwb_en;
   assign hz.ifid_flush  = ifid_fl;
   assign hz.idex_flush  = idex_fl;
   assign hz.exmem_flush = exmem_fl;
   assign hz.memwb_flush = memwb_fl;
   assign hz.halted      = halted;

`ifdef HAZARD_PERF_EN
   cnt_t stall_cnt;
   cnt_t flush_cnt;

   hazard_perf_ctr #(.W(CNT_W)) u_stall_ctr (
      .clk (CLK),
      .rst (RST),
      .en  (~pc_en & ~halted),
      .cnt (stall_cnt)
   );

   hazard_perf_ctr #(.W(CNT_W)) u_flush_ctr (
      .clk (CLK),
      .rst (RST),
      .en  (br_apply),
      .cnt (flush_cnt)
   );

   assign hz.stall_cnt = stall_cnt;
   assign hz.flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: expected control words
// queued at drive time, popped and compared at the negedge.
module tb_hazard_unit;
   import cpu_types_pkg::*;

   // {halted,pc,ifid,idex,exmem,memwb,f_ifid,f_idex,f_exmem,f_memwb}
   localparam bit [9:0] FREE = 10'b0_11111_0000;
   localparam bit [9:0] FRZ  = 10'b0_00000_0000;
   localparam bit [9:0] BR   = 10'b0_11111_1110;
   localparam bit [9:0] LU   = 10'b0_00111_0100;
   localparam bit [9:0] IM   = 10'b0_01111_1000;
   localparam bit [9:0] HLT  = 10'b1_00000_0000;

   typedef struct {
      bit       rst;
      bit [4:0] rs1;
      bit [4:0] rs2;
      bit       urs;
      bit       urt;
      bit       mr;
      bit [4:0] wr;
      bit       dren;
      bit       dwen;
      bit       dhit;
      bit       ihit;
      bit       pcsrc;
      bit       halt;
      bit [9:0] exp;
   } stim_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   passed = 0;
   bit [9:0] sb[$];

   always #5 clk = ~clk;

   hazard_if #(.CNT_W(4)) hz ();

   hazard_unit #(.CNT_W(4)) dut (
      .CLK (clk),
      .RST (rst),
      .hz  (hz.hazard)
   );

   function automatic bit [9:0] obs();
      return {hz.halted, hz.pc_en, hz.ifid_en,
              hz.idex_en, hz.exmem_en, hz.memwb_en,
              hz.ifid_flush, hz.idex_flush,
              hz.exmem_flush, hz.memwb_flush};
   endfunction

   function automatic stim_t idle(input bit [9:0] e);
      stim_t s;
      s = '{default: '0};
      s.ihit = 1'b1;
      s.exp = e;
      return s;
   endfunction

   // apply one cycle of stimulus after the edge and queue its expectation
   task automatic drive(input stim_t s);
      @(posedge clk);
      #1;
      rst            = s.rst;
      hz.rsel1       = s.rs1;
      hz.rsel2       = s.rs2;
      hz.use_rs      = s.urs;
      hz.use_rt      = s.urt;
      hz.ex_memRead  = s.mr;
      hz.ex_writeReg = s.wr;
      hz.mem_dREN    = s.dren;
      hz.mem_dWEN    = s.dwen;
      hz.dhit        = s.dhit;
      hz.ihit        = s.ihit;
      hz.mem_pcsrc   = s.pcsrc;
      hz.wb_halt     = s.halt;
      sb.push_back(s.exp);
   endtask

   task automatic test_reset();
      stim_t s;
      bit [9:0] e;
      s = idle(FREE);
      s.rst = 1'b1;
      drive(s);
      void'(sb.pop_front());
      drive(idle(FREE));
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs() !== e || dut.state_q !== RUN)
         $display("FAIL reset: got %b st=%0d want %b st=0",
                  obs(), dut.state_q, e);
      else passed++;
   endtask

   task automatic test_load_use();
      stim_t t[5];
      bit [9:0] e;
      t[0] = idle(LU);
      t[0].rs1 = 5'd8; t[0].urs = 1; t[0].mr = 1; t[0].wr = 5'd8;
      t[1] = idle(FREE);
      t[1].rs1 = 5'd8; t[1].urs = 1;
      t[2] = idle(FREE);
      t[2].urs = 1; t[2].mr = 1;
      t[3] = idle(LU);
      t[3].rs2 = 5'd9; t[3].urt = 1; t[3].mr = 1; t[3].wr = 5'd9;
      t[4] = idle(FREE);
      t[4].rs1 = 5'd9; t[4].mr = 1; t[4].wr = 5'd9;
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e)
            $display("FAIL load_use[%0d]: got %b want %b",
                     i, obs(), e);
         else passed++;
      end
   endtask

   task automatic test_dmiss();
      stim_t s;
      bit [9:0] e;
      for (int i = 0; i < 5; i++) begin
         s = idle(i < 4 ? FRZ : FREE);
         s.dren = 1'b1;
         s.dhit = (i == 4);
         drive(s);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e)
            $display("FAIL dmiss[%0d]: got %b want %b",
                     i, obs(), e);
         else passed++;
         if (i == 3) begin
            total++;
            if (dut.state_q !== DWAIT)
               $display("FAIL dmiss_state: got %0d want %0d",
                        dut.state_q, DWAIT);
            else passed++;
         end
      end
      drive(idle(FREE));
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (obs() !== e || dut.state_q !== RUN)
         $display("FAIL dmiss_release: got %b st=%0d want %b st=0",
                  obs(), dut.state_q, e);
      else passed++;
   endtask

   task automatic test_branch_miss();
      stim_t s;
      bit [9:0] e;
      for (int i = 0; i < 4; i++) begin
         s = idle(i < 2 ? FRZ : (i == 2 ? BR : FREE));
         s.dren  = (i < 3);
         s.dhit  = (i == 2);
         s.pcsrc = (i < 3);
         s.ihit  = (i != 2);
         drive(s);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e)
            $display("FAIL branch_miss[%0d]: got %b want %b",
                     i, obs(), e);
         else passed++;
      end
   endtask

   task automatic test_imiss_vs_lu();
      stim_t t[3];
      bit [9:0] e;
      t[0] = idle(LU);
      t[0].ihit = 0; t[0].rs1 = 5'd4; t[0].urs = 1;
      t[0].mr = 1; t[0].wr = 5'd4;
      t[1] = idle(IM);
      t[1].ihit = 0;
      t[2] = idle(BR);
      t[2].ihit = 0; t[2].pcsrc = 1;
      t[2].rs1 = 5'd4; t[2].urs = 1; t[2].mr = 1; t[2].wr = 5'd4;
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e)
            $display("FAIL imiss_lu[%0d]: got %b want %b",
                     i, obs(), e);
         else passed++;
      end
   endtask

   task automatic test_halt();
      stim_t t[6];
      bit [9:0] e;
      t[0] = idle(FREE);
      t[0].halt = 1;
      t[1] = idle(HLT);
      t[1].dren = 1;
      t[2] = idle(HLT);
      t[2].pcsrc = 1;
      t[3] = idle(HLT);
      t[3].ihit = 0; t[3].rs1 = 5'd3; t[3].urs = 1;
      t[3].mr = 1; t[3].wr = 5'd3;
      t[4] = idle(HLT);
      t[4].rst = 1;
      t[5] = idle(FREE);
      foreach (t[i]) begin
         drive(t[i]);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e)
            $display("FAIL halt[%0d]: got %b want %b",
                     i, obs(), e);
         else passed++;
      end
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      stim_t s;
      bit [9:0] e;
      s = idle(FREE);
      s.rst = 1;
      drive(s);
      void'(sb.pop_front());
      for (int i = 0; i < 17; i++) begin
         s = idle(IM);
         s.ihit = 0;
         drive(s);
         @(negedge clk);
         e = sb.pop_front();
         total++;
         if (obs() !== e)
            $display("FAIL perf_stall[%0d]: got %b want %b",
                     i, obs(), e);
         else passed++;
      end
      for (int i = 0; i < 2; i++) begin
         s = idle(BR);
         s.pcsrc = 1;
         drive(s);
         @(negedge clk);
         void'(sb.pop_front());
      end
      drive(idle(FREE));
      @(negedge clk);
      void'(sb.pop_front());
      total++;
      if (hz.stall_cnt !== 4'd1 || hz.flush_cnt !== 4'd2)
         $display("FAIL perf_cnt: got s=%0d f=%0d want s=1 f=2",
                  hz.stall_cnt, hz.flush_cnt);
      else passed++;
   endtask
`endif

   initial begin
      rst = 1'b1;
      hz.rsel1 = '0; hz.rsel2 = '0;
      hz.use_rs = 0; hz.use_rt = 0;
      hz.ex_memRead = 0; hz.ex_writeReg = '0;
      hz.mem_dREN = 0; hz.mem_dWEN = 0;
      hz.dhit = 0; hz.ihit = 1;
      hz.mem_pcsrc = 0; hz.wb_halt = 0;
      test_reset();
      test_load_use();
      test_dmiss();
      test_branch_miss();
      test_imiss_vs_lu();
      test_halt();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
